// File: rtl/proc_mem_pkg.sv
// rtl/proc_mem_pkg.sv - shared types and constants for the processor memory arbiter
package proc_mem_pkg;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef struct packed {
        logic        req_type;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } mem_src_t;

    typedef enum logic {
        PRI_I = 1'b0,
        PRI_D = 1'b1
    } pri_state_t;

endpackage

// File: rtl/mem_arb_id_queue.sv
// rtl/mem_arb_id_queue.sv - 1-bit source-ID FIFO tracking in-flight memory requests
module mem_arb_id_queue #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW:0]   CNT_MAX = DEPTH[PW:0];

    logic [DEPTH-1:0] ids;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A push is refused when full even if a pop frees a slot this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign head    = ids[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ID storage needs no reset: entries are only read while count covers them.
    always_ff @(posedge clk) begin
        if (do_push) ids[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/proc_mem_arbiter.sv
// rtl/proc_mem_arbiter.sv - round-robin I/D arbiter onto one in-order memory port
module proc_mem_arbiter
    import proc_mem_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemreq_val,
    output logic        imemreq_rdy,
    input  logic [31:0] imemreq_addr,
    output logic        imemresp_val,
    input  logic        imemresp_rdy,
    output logic [31:0] imemresp_data,
    input  logic        dmemreq_val,
    output logic        dmemreq_rdy,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic        dmemresp_val,
    input  logic        dmemresp_rdy,
    output logic [31:0] dmemresp_data,
    output logic        memreq_val,
    input  logic        memreq_rdy,
    output logic        memreq_type,
    output logic [31:0] memreq_addr,
    output logic [31:0] memreq_wdata,
    input  logic        memresp_val,
    output logic        memresp_rdy,
    input  logic [31:0] memresp_data
);
    pri_state_t pri;
    pri_state_t pri_next;
    mem_req_t   req;
    mem_src_t   head_src;
    logic       full;
    logic       empty;
    logic       head;
    logic       grant_d;
    logic       req_fire;
    logic       resp_fire;

    // D wins when it is the only requester or when the pointer favours it.
    assign grant_d = dmemreq_val & (~imemreq_val | (pri == PRI_D));

    // Request fields come from the granted port; fetches are always plain reads.
    always_comb begin
        req = '{req_type: MEM_READ, addr: imemreq_addr, wdata: 32'h0};
        if (grant_d) begin
            req = '{req_type: dmemreq_type, addr: dmemreq_addr, wdata: dmemreq_wdata};
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign memreq_val   = rst & (imemreq_val | dmemreq_val) & ~full;
    assign memreq_type  = req.req_type;
    assign memreq_addr  = req.addr;
    assign memreq_wdata = req.wdata;
    assign imemreq_rdy  = rst & memreq_rdy & ~full & ~grant_d;
    assign dmemreq_rdy  = rst & memreq_rdy & ~full & grant_d;
    assign req_fire     = memreq_val & memreq_rdy;

    // Priority pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pri <= PRI_I;
        else      pri <= pri_next;
    end

    // After any grant, the port that lost (or was idle) gets priority next.
    always_comb begin
        pri_next = pri;
        if (req_fire) begin
            pri_next = grant_d ? PRI_I : PRI_D;
        end
    end

    mem_arb_id_queue #(
        .DEPTH(MAX_INFLIGHT)
    ) u_id_queue (
        .clk     (clk),
        .rst     (rst),
        .push    (req_fire),
        .push_id (grant_d),
        .pop     (resp_fire),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    // Response routing follows the oldest outstanding request's source.
    assign head_src      = mem_src_t'(head);
    assign memresp_rdy   = rst & ~empty & ((head_src == SRC_D) ? dmemresp_rdy : imemresp_rdy);
    assign imemresp_val  = rst & memresp_val & ~empty & (head_src == SRC_I);
    assign dmemresp_val  = rst & memresp_val & ~empty & (head_src == SRC_D);
    assign imemresp_data = memresp_data;
    assign dmemresp_data = memresp_data;
    assign resp_fire     = memresp_val & memresp_rdy;

    a_resp_without_request: assert property (@(posedge clk) disable iff (!rst) !(memresp_val && empty));

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// tb/tb_proc_mem_arbiter.sv - scoreboard bench for proc_mem_arbiter
module tb_proc_mem_arbiter;
    localparam int MAXI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        imemreq_val = 1'b0, imemreq_rdy, imemresp_val, imemresp_rdy = 1'b0;
    logic [31:0] imemreq_addr = '0, imemresp_data;
    logic        dmemreq_val = 1'b0, dmemreq_rdy, dmemreq_type = 1'b0, dmemresp_val, dmemresp_rdy = 1'b0;
    logic [31:0] dmemreq_addr = '0, dmemreq_wdata = '0, dmemresp_data;
    logic        memreq_val, memreq_rdy = 1'b0, memreq_type, memresp_val = 1'b0, memresp_rdy;
    logic [31:0] memreq_addr, memreq_wdata, memresp_data = '0;

    proc_mem_arbiter #(.MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .rst(rst),
        .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
        .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy), .imemresp_data(imemresp_data),
        .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
        .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
        .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy), .dmemresp_data(dmemresp_data),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
        .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_data(memresp_data)
    );

    typedef struct {
        bit          src;
        bit          wr;
        logic [31:0] data;
    } rsp_t;

    rsp_t        mem_q[$];
    rsp_t        exp_i[$];
    rsp_t        exp_d[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] grant_log[$];
    logic [31:0] log_i[$];
    logic [31:0] log_d[$];
    int          grant_i_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          inflight = 0;
    bit          pref_i = 1'b1;
    bit          stray = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0;
    int unsigned p_ival = 0, p_dval = 0, p_dwrite = 0, p_mreq_rdy = 0;
    int unsigned p_mresp = 0, p_irdy = 0, p_drdy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    // Reference model: round-robin grant, bounded in-flight count, in-order memory.
    always @(negedge clk) begin : model
        bit          exp_val, win_d, exp_mrdy, hsrc, has_head;
        logic [31:0] a;
        rsp_t        r;
        if (!rst) begin
            chk("rst_imemreq_rdy", 32'(imemreq_rdy), 32'h0);
            chk("rst_dmemreq_rdy", 32'(dmemreq_rdy), 32'h0);
            chk("rst_memreq_val", 32'(memreq_val), 32'h0);
            chk("rst_memresp_rdy", 32'(memresp_rdy), 32'h0);
            chk("rst_imemresp_val", 32'(imemresp_val), 32'h0);
            chk("rst_dmemresp_val", 32'(dmemresp_val), 32'h0);
            mem_q.delete();
            exp_i.delete();
            exp_d.delete();
            inflight = 0;
            pref_i = 1'b1;
        end else begin
            exp_val = (imemreq_val || dmemreq_val) && (inflight < MAXI);
            win_d = dmemreq_val && (!imemreq_val || !pref_i);
            chk("memreq_val", 32'(memreq_val), 32'(exp_val));
            if (exp_val) begin
                chk("imemreq_rdy", 32'(imemreq_rdy), 32'(!win_d && memreq_rdy));
                chk("dmemreq_rdy", 32'(dmemreq_rdy), 32'(win_d && memreq_rdy));
                chk("memreq_type", 32'(memreq_type), 32'(win_d && dmemreq_type));
                chk("memreq_addr", memreq_addr, win_d ? dmemreq_addr : imemreq_addr);
                chk("memreq_wdata", memreq_wdata, win_d ? dmemreq_wdata : 32'h0);
            end else if (inflight == MAXI) begin
                chk("full_imemreq_rdy", 32'(imemreq_rdy), 32'h0);
                chk("full_dmemreq_rdy", 32'(dmemreq_rdy), 32'h0);
            end
            has_head = (mem_q.size() > 0);
            hsrc = has_head ? mem_q[0].src : 1'b0;
            exp_mrdy = has_head && (hsrc ? dmemresp_rdy : imemresp_rdy);
            chk("memresp_rdy", 32'(memresp_rdy), 32'(exp_mrdy));
            chk("imemresp_val", 32'(imemresp_val), 32'(memresp_val && has_head && !hsrc));
            chk("dmemresp_val", 32'(dmemresp_val), 32'(memresp_val && has_head && hsrc));
            if (memresp_val && exp_mrdy) begin
                void'(mem_q.pop_front());
                inflight--;
            end
            if (exp_val && memreq_rdy) begin
                a = win_d ? dmemreq_addr : imemreq_addr;
                r.src = win_d;
                r.wr = win_d && dmemreq_type;
                if (r.wr) begin
                    mem[a] = dmemreq_wdata;
                    r.data = 32'h0;
                end else begin
                    r.data = mem_rd(a);
                end
                mem_q.push_back(r);
                if (win_d) exp_d.push_back(r);
                else       exp_i.push_back(r);
                grant_log.push_back(a);
                if (!win_d) grant_i_cnt++;
                if (win_d) daddr += 32'd4;
                else       iaddr += 32'd4;
                pref_i = win_d;
                inflight++;
            end
        end
    end

    // Monitor: pop expected responses when either requester consumes one.
    always @(negedge clk) begin : monitor
        rsp_t r;
        if (rst) begin
            if (imemresp_val && imemresp_rdy) begin
                if (exp_i.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL imemresp_unexpected: got data %h, expected no response", imemresp_data);
                end else begin
                    r = exp_i.pop_front();
                    chk("imemresp_data", imemresp_data, r.data);
                    log_i.push_back(imemresp_data);
                end
            end
            if (dmemresp_val && dmemresp_rdy) begin
                if (exp_d.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL dmemresp_unexpected: got data %h, expected no response", dmemresp_data);
                end else begin
                    r = exp_d.pop_front();
                    if (!r.wr) chk("dmemresp_data", dmemresp_data, r.data);
                    log_d.push_back(dmemresp_data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        imemreq_val   = ($urandom_range(99) < p_ival);
        imemreq_addr  = iaddr;
        dmemreq_val   = ($urandom_range(99) < p_dval);
        dmemreq_type  = ($urandom_range(99) < p_dwrite);
        dmemreq_addr  = daddr;
        dmemreq_wdata = $urandom;
        memreq_rdy    = ($urandom_range(99) < p_mreq_rdy);
        imemresp_rdy  = ($urandom_range(99) < p_irdy);
        dmemresp_rdy  = ($urandom_range(99) < p_drdy);
        memresp_val   = stray || ((mem_q.size() > 0) && ($urandom_range(99) < p_mresp));
        memresp_data  = (mem_q.size() > 0) ? mem_q[0].data : $urandom;
    endtask

    task automatic issue(input bit is_d, input bit wr);
        p_ival = is_d ? 0 : 100;
        p_dval = is_d ? 100 : 0;
        p_dwrite = wr ? 100 : 0;
        step();
        p_ival = 0;
        p_dval = 0;
    endtask

    task automatic drain();
        p_ival = 0; p_dval = 0; p_mresp = 100; p_irdy = 100; p_drdy = 100; p_mreq_rdy = 100;
        repeat (16) step();
        chk("drain_empty", 32'(mem_q.size()), 32'h0);
    endtask

    logic [31:0] exp_seq[4] = '{32'h100, 32'h200, 32'h104, 32'h204};

    initial begin
        // Reset held with random activity on every input.
        p_ival = 50; p_dval = 50; p_dwrite = 50; p_mreq_rdy = 50;
        p_mresp = 50; p_irdy = 50; p_drdy = 50;
        repeat (8) begin
            stray = ($urandom_range(1) == 1);
            step();
        end
        stray = 1'b0;
        iaddr = 32'h100;
        daddr = 32'h200;
        p_ival = 100; p_dval = 100; p_dwrite = 0; p_mreq_rdy = 100;
        p_mresp = 0; p_irdy = 100; p_drdy = 100;
        step();
        rst = 1'b1;
        grant_log.delete();

        // Contention into full: four alternating grants, then issue stalls.
        repeat (8) step();
        chk("full_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) chk($sformatf("contention_addr%0d", i), grant_log[i], exp_seq[i]);
        end
        p_mresp = 100;
        repeat (6) step();
        drain();

        // Routing: I read, D write, D read.
        p_mresp = 0;
        mem[iaddr] = 32'hAAAA;
        mem[daddr + 32'd4] = 32'hBBBB;
        log_i.delete();
        log_d.delete();
        issue(1'b0, 1'b0);
        issue(1'b1, 1'b1);
        issue(1'b1, 1'b0);
        drain();
        chk("route_i_count", 32'(log_i.size()), 32'd1);
        if (log_i.size() > 0) chk("route_i_data", log_i[0], 32'hAAAA);
        chk("route_d_count", 32'(log_d.size()), 32'd2);
        if (log_d.size() == 2) chk("route_d_last", log_d[1], 32'hBBBB);

        // Back-pressure: stalled D response at the head, I keeps issuing to full.
        p_drdy = 0; p_irdy = 100; p_mresp = 100; p_mreq_rdy = 100;
        issue(1'b1, 1'b0);
        grant_i_cnt = 0;
        p_ival = 100;
        repeat (8) step();
        chk("bp_i_grants", 32'(grant_i_cnt), 32'd3);
        chk("bp_inflight", 32'(inflight), 32'd4);
        drain();

        // Reset with three requests outstanding, plus a stray response.
        p_mresp = 0;
        p_ival = 100;
        repeat (3) step();
        p_ival = 0;
        step();
        chk("mid_inflight", 32'(inflight), 32'd3);
        rst = 1'b0;
        stray = 1'b1;
        step();
        #1;
        chk("stray_memresp_rdy", 32'(memresp_rdy), 32'h0);
        step();
        stray = 1'b0;
        p_ival = 100; p_dval = 100; p_dwrite = 0; p_mreq_rdy = 100;
        step();
        rst = 1'b1;
        grant_log.delete();
        repeat (8) step();
        chk("post_reset_grants", 32'(grant_log.size()), 32'd4);
        drain();

        // Randomized traffic with shifting rates.
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                p_ival = $urandom_range(100);
                p_dval = $urandom_range(100);
                p_dwrite = $urandom_range(100);
                p_mreq_rdy = $urandom_range(20, 100);
                p_mresp = $urandom_range(10, 100);
                p_irdy = $urandom_range(10, 100);
                p_drdy = $urandom_range(10, 100);
            end
            step();
        end
        drain();
        chk("end_exp_i_empty", 32'(exp_i.size()), 32'h0);
        chk("end_exp_d_empty", 32'(exp_d.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
